request_dispatcher: RTL and testbench

Downstream consumer of the request queue: collects the slot IDs the queue reports on each completed push, keeps them in arrival order, and drains requests in FIFO order. For each one it issues a pop to the queue and captures the returned data into a 4-entry output buffer. The buffer feeds a valid/ready request stream toward the RPC processing units. Credit accounting over the pop pipeline guarantees no captured request is ever dropped and sustains one request per cycle.

---
 rtl/request_dispatcher.sv | 162 ++++++++++++++++
 tb/tb_request_dispatcher.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/request_dispatcher.sv
// request_dispatcher
//
// Collects slot IDs reported by the request queue on each completed push,
// keeps them in arrival order, and drains them in FIFO order. Each drained ID
// becomes a registered pop toward the queue. The read data returns one cycle
// later and is captured into a 4-entry output buffer that feeds a valid/ready
// request stream. Credits cover the pop pipeline, so a captured word always
// has a free buffer entry.
//
// Ports
//   clk, reset            clock, synchronous active-high reset
//   enable                permits new pops (in-flight pops still complete)
//   slot_valid_in         queue push completed, slot_id_in = slot written
//   rq_pop_en_out         registered pop strobe to the queue
//   rq_pop_slot_id_out    registered slot to read and free (holds when idle)
//   rq_pop_data_in        queue read data, valid the cycle after a pop
//   out_valid/out_ready   request stream handshake
//   out_data/out_slot_id  request word and its source slot
//   pending_count         IDs currently waiting in the ID FIFO
//   error                 sticky ID-FIFO overflow flag
module request_dispatcher #(
  parameter int DATA_WIDTH = 8,
  parameter int LSIZE      = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  slot_valid_in,
  input  logic [LSIZE-1:0]      slot_id_in,
  output logic                  rq_pop_en_out,
  output logic [LSIZE-1:0]      rq_pop_slot_id_out,
  input  logic [DATA_WIDTH-1:0] rq_pop_data_in,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [LSIZE-1:0]      out_slot_id,
  input  logic                  out_ready,
  output logic [LSIZE:0]        pending_count,
  output logic                  error
);

  localparam int             DEPTH   = 1 << LSIZE;
  localparam logic [LSIZE:0] ID_FULL = (LSIZE+1)'(DEPTH);

  // ID FIFO
  logic [LSIZE-1:0] id_mem_q [DEPTH];
  logic [LSIZE-1:0] id_wr_ptr_q, id_wr_ptr_d;
  logic [LSIZE-1:0] id_rd_ptr_q, id_rd_ptr_d;
  logic [LSIZE:0]   id_cnt_q, id_cnt_d;
  logic             id_empty, id_full, id_wr, id_rd, overflow;

  // Output buffer
  logic [DATA_WIDTH-1:0] ob_data_q [4];
  logic [LSIZE-1:0]      ob_id_q   [4];
  logic [1:0]            ob_wr_ptr_q, ob_rd_ptr_q;
  logic [2:0]            ob_cnt_q, ob_cnt_d;
  logic                  ob_enq, ob_deq;

  // Pop pipeline
  logic             pop_en_q, pop_en_d;
  logic [LSIZE-1:0] pop_id_q, pop_id_d;
  logic             cap_q;
  logic [LSIZE-1:0] cap_id_q;
  logic [1:0]       inflight_q, inflight_d;
  logic [2:0]       credits_used;
  logic             issue;
  logic             error_q, error_d;

  assign id_empty = (id_cnt_q == '0);
  assign id_full  = (id_cnt_q == ID_FULL);

  // Buffer entries already spoken for: occupied plus pops still on their way.
  assign credits_used = ob_cnt_q + {1'b0, inflight_q};
  assign issue        = enable && !id_empty && (credits_used < 3'd4);

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign id_rd    = issue;
  assign id_wr    = slot_valid_in && (!id_full || id_rd);
  assign overflow = slot_valid_in && id_full && !id_rd;

  assign ob_enq = cap_q;
  assign ob_deq = out_valid && out_ready;

  always_comb begin
    id_wr_ptr_d = id_wr_ptr_q;
    id_rd_ptr_d = id_rd_ptr_q;
    id_cnt_d    = id_cnt_q;
    if (id_wr) id_wr_ptr_d = id_wr_ptr_q + 1'b1;
    if (id_rd) id_rd_ptr_d = id_rd_ptr_q + 1'b1;
    case ({id_wr, id_rd})
      2'b10:   id_cnt_d = id_cnt_q + 1'b1;
      2'b01:   id_cnt_d = id_cnt_q - 1'b1;
      default: id_cnt_d = id_cnt_q;
    endcase

    ob_cnt_d = ob_cnt_q;
    case ({ob_enq, ob_deq})
      2'b10:   ob_cnt_d = ob_cnt_q + 1'b1;
      2'b01:   ob_cnt_d = ob_cnt_q - 1'b1;
      default: ob_cnt_d = ob_cnt_q;
    endcase

    inflight_d = inflight_q;
    case ({issue, cap_q})
      2'b10:   inflight_d = inflight_q + 1'b1;
      2'b01:   inflight_d = inflight_q - 1'b1;
      default: inflight_d = inflight_q;
    endcase

    pop_en_d = issue;
    pop_id_d = issue ? id_mem_q[id_rd_ptr_q] : pop_id_q;
    error_d  = error_q | overflow;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      id_wr_ptr_q <= '0;
      id_rd_ptr_q <= '0;
      id_cnt_q    <= '0;
      ob_wr_ptr_q <= '0;
      ob_rd_ptr_q <= '0;
      ob_cnt_q    <= '0;
      pop_en_q    <= 1'b0;
      pop_id_q    <= '0;
      cap_q       <= 1'b0;
      cap_id_q    <= '0;
      inflight_q  <= '0;
      error_q     <= 1'b0;
    end else begin
      id_wr_ptr_q <= id_wr_ptr_d;
      id_rd_ptr_q <= id_rd_ptr_d;
      id_cnt_q    <= id_cnt_d;
      if (ob_enq) ob_wr_ptr_q <= ob_wr_ptr_q + 1'b1;
      if (ob_deq) ob_rd_ptr_q <= ob_rd_ptr_q + 1'b1;
      ob_cnt_q    <= ob_cnt_d;
      pop_en_q    <= pop_en_d;
      pop_id_q    <= pop_id_d;
      // Read data arrives one cycle after the pop; carry the slot alongside.
      cap_q       <= pop_en_q;
      cap_id_q    <= pop_id_q;
      inflight_q  <= inflight_d;
      error_q     <= error_d;
    end
  end

  // Storage arrays carry no reset; occupancy is tracked by the counters.
  always_ff @(posedge clk) begin
    if (!reset && id_wr) id_mem_q[id_wr_ptr_q] <= slot_id_in;
    if (!reset && ob_enq) begin
      ob_data_q[ob_wr_ptr_q] <= rq_pop_data_in;
      ob_id_q[ob_wr_ptr_q]   <= cap_id_q;
    end
  end

  assign rq_pop_en_out      = pop_en_q;
  assign rq_pop_slot_id_out = pop_id_q;
  assign out_valid          = (ob_cnt_q != 3'd0);
  assign out_data           = out_valid ? ob_data_q[ob_rd_ptr_q] : '0;
  assign out_slot_id        = out_valid ? ob_id_q[ob_rd_ptr_q] : '0;
  assign pending_count      = id_cnt_q;
  assign error              = error_q;

endmodule

// File: tb/tb_request_dispatcher.sv
module tb_request_dispatcher;
  localparam int DW = 8;
  localparam int LS = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          enable = 1'b0;
  logic          slot_valid_in = 1'b0;
  logic [LS-1:0] slot_id_in = '0;
  logic          rq_pop_en_out;
  logic [LS-1:0] rq_pop_slot_id_out;
  logic [DW-1:0] rq_pop_data_in = '0;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic [LS-1:0] out_slot_id;
  logic          out_ready = 1'b0;
  logic [LS:0]   pending_count;
  logic          error;

  request_dispatcher #(.DATA_WIDTH(DW), .LSIZE(LS)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .slot_valid_in(slot_valid_in), .slot_id_in(slot_id_in),
    .rq_pop_en_out(rq_pop_en_out), .rq_pop_slot_id_out(rq_pop_slot_id_out),
    .rq_pop_data_in(rq_pop_data_in),
    .out_valid(out_valid), .out_data(out_data), .out_slot_id(out_slot_id),
    .out_ready(out_ready), .pending_count(pending_count), .error(error)
  );

  always #5 clk = ~clk;

  // Queue stand-in: fixed content per slot, junk when no pop was issued.
  logic [DW-1:0] qmem [16];
  always @(posedge clk)
    rq_pop_data_in <= rq_pop_en_out ? qmem[rq_pop_slot_id_out] : DW'($urandom);

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: ID list, output list, and the two pop stages as plain values.
  typedef struct packed { logic [DW-1:0] d; logic [LS-1:0] id; } ent_t;
  logic [LS-1:0] m_ids [$];
  ent_t          m_ob  [$];
  bit            m_pop_en, m_cap, m_err, m_started = 0;
  logic [LS-1:0] m_pop_id, m_cap_id, m_head;
  bit            m_iss;

  task automatic model_step();
    if (reset) begin
      m_ids.delete(); m_ob.delete();
      m_pop_en = 0; m_cap = 0; m_err = 0;
      m_pop_id = '0; m_cap_id = '0;
      m_started = 1;
    end else begin
      m_iss = enable && (m_ids.size() > 0) &&
              (m_ob.size() + int'(m_pop_en) + int'(m_cap) < 4);
      if (m_ob.size() > 0 && out_ready) void'(m_ob.pop_front());
      if (m_cap) m_ob.push_back(ent_t'{d: qmem[m_cap_id], id: m_cap_id});
      if (m_iss) m_head = m_ids.pop_front();
      if (slot_valid_in) begin
        if (m_ids.size() == 16) m_err = 1;
        else m_ids.push_back(slot_id_in);
      end
      m_cap    = m_pop_en;
      m_cap_id = m_pop_id;
      m_pop_en = m_iss;
      if (m_iss) m_pop_id = m_head;
    end
  endtask

  always @(posedge clk) model_step();

  // Per-cycle comparison plus simple activity counters.
  int n_pops = 0, n_outs = 0, pop_run = 0, max_pop_run = 0, out_run = 0, max_out_run = 0;
  always @(negedge clk) begin
    if (m_started) begin
      chk("pop_en", rq_pop_en_out, m_pop_en);
      chk("pop_id", rq_pop_slot_id_out, m_pop_id);
      chk("out_valid", out_valid, m_ob.size() > 0);
      if (m_ob.size() > 0) begin
        chk("out_data", out_data, m_ob[0].d);
        chk("out_slot_id", out_slot_id, m_ob[0].id);
      end
      chk("pending_count", pending_count, m_ids.size());
      chk("error", error, m_err);
    end
    if (rq_pop_en_out) begin n_pops++; pop_run++; end else pop_run = 0;
    if (pop_run > max_pop_run) max_pop_run = pop_run;
    if (out_valid && out_ready) begin n_outs++; out_run++; end else out_run = 0;
    if (out_run > max_out_run) max_out_run = out_run;
  end

  task automatic idle(input int n);
    slot_valid_in = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  int  p0, o0;
  bit  seen;
  int  rate;

  initial begin
    for (int i = 0; i < 16; i++) qmem[i] = DW'($urandom);
    qmem[5] = 8'hA5;
    repeat (3) @(negedge clk);
    chk("rst_pop_en", rq_pop_en_out, 0);
    chk("rst_pop_id", rq_pop_slot_id_out, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_slot", out_slot_id, 0);
    chk("rst_pending", pending_count, 0);
    chk("rst_error", error, 0);
    reset = 1'b0;
    idle(2);

    // Single request, id 5 pushed in cycle T
    enable = 1'b1; out_ready = 1'b1;
    slot_valid_in = 1'b1; slot_id_in = 4'd5;
    @(negedge clk); slot_valid_in = 1'b0;
    chk("single_t1_pop", rq_pop_en_out, 0);
    @(negedge clk);
    chk("single_t2_pop", rq_pop_en_out, 1);
    chk("single_t2_id", rq_pop_slot_id_out, 5);
    @(negedge clk);
    chk("single_t3_valid", out_valid, 0);
    @(negedge clk);
    chk("single_t4_valid", out_valid, 1);
    chk("single_t4_data", out_data, 8'hA5);
    chk("single_t4_slot", out_slot_id, 5);
    @(negedge clk);
    chk("single_t5_valid", out_valid, 0);
    idle(3);

    // Burst of ids 0..15
    p0 = n_pops; o0 = n_outs; max_pop_run = 0; max_out_run = 0;
    for (int i = 0; i < 16; i++) begin
      slot_valid_in = 1'b1; slot_id_in = LS'(i);
      @(negedge clk);
    end
    idle(12);
    chk("burst_pops", n_pops - p0, 16);
    chk("burst_pop_run", max_pop_run, 16);
    chk("burst_outs", n_outs - o0, 16);
    chk("burst_out_run", max_out_run, 16);
    chk("burst_error", error, 0);

    // Backpressure
    out_ready = 1'b0; p0 = n_pops; o0 = n_outs;
    for (int i = 0; i < 8; i++) begin
      slot_valid_in = 1'b1; slot_id_in = LS'($urandom);
      @(negedge clk);
    end
    idle(10);
    chk("bp_pops", n_pops - p0, 4);
    chk("bp_valid", out_valid, 1);
    chk("bp_pending", pending_count, 4);
    out_ready = 1'b1;
    idle(20);
    chk("bp_outs", n_outs - o0, 8);
    chk("bp_pending_end", pending_count, 0);

    // Overflow with issue paused
    enable = 1'b0; p0 = n_pops;
    for (int i = 0; i < 17; i++) begin
      if (i == 16) chk("ovf_err_before", error, 0);
      slot_valid_in = 1'b1; slot_id_in = LS'($urandom);
      @(negedge clk);
    end
    slot_valid_in = 1'b0;
    chk("ovf_pending", pending_count, 16);
    chk("ovf_error", error, 1);
    enable = 1'b1;
    idle(30);
    chk("ovf_pops", n_pops - p0, 16);
    chk("ovf_error_sticky", error, 1);

    // Full FIFO with push in the first issue cycle
    do_reset();
    enable = 1'b0;
    for (int i = 0; i < 16; i++) begin
      slot_valid_in = 1'b1; slot_id_in = LS'(15 - i);
      @(negedge clk);
    end
    enable = 1'b1; slot_valid_in = 1'b1; slot_id_in = 4'd9;
    @(negedge clk);
    slot_valid_in = 1'b0; enable = 1'b0;
    chk("fullrd_pop", rq_pop_en_out, 1);
    chk("fullrd_pending", pending_count, 16);
    chk("fullrd_error", error, 0);
    enable = 1'b1;
    idle(30);
    chk("fullrd_drained", pending_count, 0);
    chk("fullrd_error_end", error, 0);

    // Reset one cycle after a pop
    for (int i = 0; i < 3; i++) begin
      slot_valid_in = 1'b1; slot_id_in = LS'($urandom);
      @(negedge clk);
    end
    slot_valid_in = 1'b0;
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      if (rq_pop_en_out) seen = 1;
      else @(negedge clk);
    end
    chk("rstmid_pop_seen", seen, 1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rstmid_valid", out_valid, 0);
    chk("rstmid_pending", pending_count, 0);
    chk("rstmid_pop_en", rq_pop_en_out, 0);
    o0 = n_outs;
    idle(6);
    chk("rstmid_no_output", n_outs - o0, 0);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      rate = (c / 500) % 2 == 0 ? 5 : 9;
      enable        = ($urandom_range(0, 9) < 8);
      slot_valid_in = ($urandom_range(0, 9) < rate);
      slot_id_in    = LS'($urandom);
      out_ready     = ($urandom_range(0, 9) < ((c / 300) % 2 == 0 ? 9 : 3));
      reset         = ($urandom_range(0, 599) == 0);
      @(negedge clk);
    end
    reset = 1'b0; enable = 1'b1; out_ready = 1'b1;
    idle(60);
    chk("final_pending", pending_count, 0);
    chk("final_valid", out_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
